mem_bank_ctrl: RTL and testbench

- Parametrised simple-dual-port memory, successor to mem_mod: one write port, one read port, one clock.
- Adds per-byte write enables, configurable pipelined read latency with a valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request.
- Non-power-of-two depths are handled safely.
- Sits between datapath blocks as a generic scratch/register-file store.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_rd_pipe.sv | 38 +++
 rtl/mem_bank_ctrl.sv | 118 +++++++++++
 tb/tb_mem_bank_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, constants and helpers for the mem_bank_ctrl scratch memory.
package mem_pkg;

    localparam int BYTE_W         = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_ADDR   = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_bits(input int depth);
        int b;
        b = $clog2(depth);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Delay line carrying {valid, data} from the array read to the read port.
// The data of each stage only advances with a valid beat, so the output holds between reads.
module mem_rd_pipe
#(
    parameter int DATA_WIDTH = 8,
    parameter int STAGES     = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    logic                  vld_p [STAGES];
    logic [DATA_WIDTH-1:0] dat_p [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i] <= 1'b0;
                dat_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= src_valid;
            if (src_valid) dat_p[0] <= src_data;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) dat_p[i] <= dat_p[i-1];
            end
        end
    end

    assign valid = vld_p[STAGES-1];
    assign data  = dat_p[STAGES-1];

endmodule

// File: rtl/mem_bank_ctrl.sv
// Simple-dual-port scratch memory with byte enables, pipelined reads and a hardware clear sequencer.
// Define MEM_BANK_READ_BYPASS_EN to forward same-address write data into a colliding read.
module mem_bank_ctrl
    import mem_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_ADDR   = DEF_MAX_ADDR,
    parameter  int RD_LATENCY = 1,
    localparam int ADDRSIZE   = addr_bits(MAX_ADDR),
    localparam int BE_WIDTH   = DATA_WIDTH / BYTE_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDRSIZE-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDRSIZE-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDRSIZE-1:0]   cnt;
    logic [ADDRSIZE-1:0]   cnt_next;
    logic                  clr_we;
    logic [DATA_WIDTH-1:0] mem [MAX_ADDR];
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A clr request in either state restarts the sweep from address 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr) begin
                    cnt_next = '0;
                end else if (cnt == LAST_ADDR) begin
                    state_next = READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            READY: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign busy        = (state == CLEAR);
    assign wr_in_range = 32'(wr_addr) < 32'(MAX_ADDR);
    assign rd_in_range = 32'(rd_addr) < 32'(MAX_ADDR);
    assign wr_ok       = (state == READY) && wr_en && wr_in_range;
    assign rd_ok       = (state == READY) && rd_en;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array read happens before this edge's write lands; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[rd_addr];
`ifdef MEM_BANK_READ_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr)) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
`endif
    end

    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .STAGES     (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .src_valid (rd_ok),
        .src_data  (rd_word),
        .valid     (rd_valid),
        .data      (rd_data)
    );

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Bench for mem_bank_ctrl (16-bit words, depth 5, read latency 2): directed table, corner sequences, random traffic.
module tb_mem_bank_ctrl;

    localparam int DW  = 16;
    localparam int MA  = 5;
    localparam int LAT = 2;
    localparam int AW  = 3;
    localparam int BW  = 2;
`ifdef MEM_BANK_READ_BYPASS_EN
    localparam logic [DW-1:0] COL = 16'h00FF;
`else
    localparam logic [DW-1:0] COL = 16'h004A;
`endif

    logic          clk = 1'b0;
    logic          rst, clr, busy, wr_en, rd_en, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data, rd_data;
    logic [BW-1:0] wr_be;

    always #5 clk = ~clk;

    mem_bank_ctrl #(.DATA_WIDTH(DW), .MAX_ADDR(MA), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: word array, countdown of remaining clear cycles, queue of scheduled read results.
    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } pend_t;

    logic [DW-1:0] mm [MA];
    pend_t         q [$];
    int            clear_left;
    int            edge_n;
    logic [DW-1:0] last;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic start_clear();
        clear_left = MA;
        for (int i = 0; i < MA; i++) mm[i] = '0;
    endtask

    task automatic model_step(input logic r, input logic c, input logic we, input logic [AW-1:0] wa,
                              input logic [DW-1:0] wd, input logic [BW-1:0] be,
                              input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] v;
        edge_n++;
        if (r) begin
            start_clear();
            q.delete();
            last = '0;
        end else if (clear_left > 0) begin
            if (c) clear_left = MA;
            else   clear_left--;
        end else begin
            if (re) begin
                v = (int'(ra) < MA) ? mm[ra] : '0;
`ifdef MEM_BANK_READ_BYPASS_EN
                if (we && wa == ra && int'(wa) < MA) v = merge(v, wd, be);
`endif
                q.push_back('{d: v, due: edge_n + LAT - 1});
            end
            if (we && int'(wa) < MA) mm[wa] = merge(mm[wa], wd, be);
            if (c) start_clear();
        end
    endtask

    task automatic model_check();
        logic          eb, ev;
        logic [DW-1:0] ed;
        eb = (clear_left > 0);
        if (q.size() > 0 && q[0].due == edge_n) begin
            ev   = 1'b1;
            ed   = q[0].d;
            last = ed;
            void'(q.pop_front());
        end else begin
            ev = 1'b0;
            ed = last;
        end
        check("model_busy", 32'(busy), 32'(eb));
        check("model_rd_valid", 32'(rd_valid), 32'(ev));
        check("model_rd_data", 32'(rd_data), 32'(ed));
    endtask

    task automatic tick(input logic r, input logic c, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [BW-1:0] be,
                        input logic re, input logic [AW-1:0] ra);
        rst = r; clr = c; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra;
        @(posedge clk);
        #1;
        model_step(r, c, we, wa, wd, be, re, ra);
        model_check();
    endtask

    typedef struct {
        logic          c, we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        logic          re;
        logic [AW-1:0] ra;
        logic          eb, ev;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vt [$];

    task automatic row(input logic c, input logic we, input int wa, input int wd, input int be,
                       input logic re, input int ra, input logic eb, input logic ev, input int ed);
        vt.push_back('{c: c, we: we, wa: AW'(wa), wd: DW'(wd), be: BW'(be), re: re, ra: AW'(ra),
                       eb: eb, ev: ev, ed: DW'(ed)});
    endtask

    initial begin
        edge_n = 0;
        last   = '0;
        start_clear();

        // clear after reset: busy for 5 cycles, traffic ignored (including the write in row 4)
        row(0,0,0,0,0, 0,0, 1,0,16'h0000);
        row(0,0,0,0,0, 0,0, 1,0,16'h0000);
        row(0,0,0,0,0, 1,0, 1,0,16'h0000);
        row(0,1,1,16'h7777,3, 0,0, 1,0,16'h0000);
        row(0,0,0,0,0, 1,1, 0,0,16'h0000);
        for (int a = 0; a < MA; a++) row(0,0,0,0,0, 1,a, 0, (a != 0), 16'h0000);
        row(0,0,0,0,0, 0,0, 0,1,16'h0000);
        row(0,0,0,0,0, 0,0, 0,0,16'h0000);
        // full-word writes then back-to-back reads
        row(0,1,0,16'h1280,3, 0,0, 0,0,16'h0000);
        row(0,1,1,16'h0038,3, 0,0, 0,0,16'h0000);
        row(0,1,2,16'h004A,3, 0,0, 0,0,16'h0000);
        row(0,1,3,16'h00C8,3, 0,0, 0,0,16'h0000);
        row(0,0,0,0,0, 1,0, 0,0,16'h0000);
        row(0,0,0,0,0, 1,1, 0,1,16'h1280);
        row(0,0,0,0,0, 1,2, 0,1,16'h0038);
        row(0,0,0,0,0, 1,3, 0,1,16'h004A);
        row(0,0,0,0,0, 0,0, 0,1,16'h00C8);
        row(0,0,0,0,0, 0,0, 0,0,16'h00C8);
        // upper-byte-only write
        row(0,1,1,16'hABCD,2, 0,0, 0,0,16'h00C8);
        row(0,0,0,0,0, 1,1, 0,0,16'h00C8);
        row(0,0,0,0,0, 0,0, 0,1,16'hAB38);
        // out-of-range write dropped, out-of-range read returns 0
        row(0,1,6,16'h5555,3, 0,0, 0,0,16'hAB38);
        row(0,0,0,0,0, 1,6, 0,0,16'hAB38);
        row(0,0,0,0,0, 0,0, 0,1,16'h0000);
        row(0,0,0,0,0, 1,0, 0,0,16'h0000);
        row(0,0,0,0,0, 1,1, 0,1,16'h1280);
        row(0,0,0,0,0, 1,2, 0,1,16'hAB38);
        row(0,0,0,0,0, 1,3, 0,1,16'h004A);
        row(0,0,0,0,0, 1,4, 0,1,16'h00C8);
        row(0,0,0,0,0, 0,0, 0,1,16'h0000);
        row(0,0,0,0,0, 0,0, 0,0,16'h0000);
        // same-address write/read collision
        row(0,1,2,16'hFFFF,1, 1,2, 0,0,16'h0000);
        row(0,0,0,0,0, 1,2, 0,1,COL);
        row(0,0,0,0,0, 0,0, 0,1,16'h00FF);
        // clr with a read in flight; reads during the clear are dropped
        row(1,0,0,0,0, 1,0, 1,0,16'h00FF);
        row(0,0,0,0,0, 1,1, 1,1,16'h1280);
        row(0,0,0,0,0, 1,2, 1,0,16'h1280);
        row(0,0,0,0,0, 1,3, 1,0,16'h1280);
        row(0,0,0,0,0, 1,4, 1,0,16'h1280);
        row(0,0,0,0,0, 1,0, 0,0,16'h1280);
        row(0,0,0,0,0, 1,0, 0,0,16'h1280);
        row(0,0,0,0,0, 1,1, 0,1,16'h0000);
        row(0,0,0,0,0, 1,2, 0,1,16'h0000);
        row(0,0,0,0,0, 1,3, 0,1,16'h0000);
        row(0,0,0,0,0, 0,0, 0,1,16'h0000);
        row(0,0,0,0,0, 0,0, 0,0,16'h0000);

        // reset values
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick(1,0,0,'0,'0,'0,0,'0);
        tick(1,0,0,'0,'0,'0,0,'0);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            tick(0, vt[i].c, vt[i].we, vt[i].wa, vt[i].wd, vt[i].be, vt[i].re, vt[i].ra);
            check($sformatf("row%0d_busy", i), 32'(busy), 32'(vt[i].eb));
            check($sformatf("row%0d_rd_valid", i), 32'(rd_valid), 32'(vt[i].ev));
            check($sformatf("row%0d_rd_data", i), 32'(rd_data), 32'(vt[i].ed));
        end

        // asynchronous reset mid-clear while a read result is on the port
        tick(0,0,1,3'd3,16'h1234,2'b11, 0,3'd0);
        tick(0,0,0,3'd0,16'h0000,2'b00, 1,3'd3);
        tick(0,1,0,3'd0,16'h0000,2'b00, 0,3'd0);
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        check("pre_rst_rd_data", 32'(rd_data), 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rst_rd_data", 32'(rd_data), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd1);
        tick(1,0,0,'0,'0,'0,0,'0);
        for (int k = 0; k < MA + 2; k++) begin
            tick(0,0,1,3'(k),16'hBEEF,2'b11, 1,3'(k));
            check($sformatf("rst_clear_busy%0d", k), 32'(busy), (k < MA - 1) ? 32'd1 : 32'd0);
        end

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)),
                 DW'($urandom),
                 BW'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
